// File: rtl/router_pkg.sv
// Shared router definitions: direction codes, flit layout helpers and the XY route function.
package router_pkg;

  localparam logic [2:0] DIR_LOCAL = 3'd0;
  localparam logic [2:0] DIR_NORTH = 3'd1;
  localparam logic [2:0] DIR_SOUTH = 3'd2;
  localparam logic [2:0] DIR_EAST  = 3'd3;
  localparam logic [2:0] DIR_WEST  = 3'd4;

  localparam int DIR_W   = 3;
  localparam int COORD_W = 16;

  // Stored flit: {dir, dest, requester, read, write, data}
  function automatic int flit_width(input int addr_w, input int data_w);
    return DIR_W + 2 * addr_w + 2 + data_w;
  endfunction

  // Dimension-order routing: resolve X first, then Y; all comparisons unsigned.
  function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dest_x,
                                          input logic [COORD_W-1:0] dest_y,
                                          input logic [COORD_W-1:0] local_x,
                                          input logic [COORD_W-1:0] local_y);
    if (dest_x > local_x)      return DIR_EAST;
    else if (dest_x < local_x) return DIR_WEST;
    else if (dest_y > local_y) return DIR_SOUTH;
    else if (dest_y < local_y) return DIR_NORTH;
    else                       return DIR_LOCAL;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with naturally wrapping pointers; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; readers qualify it with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_input_buffer.sv
// Buffered router input port: XY route at enqueue, malformed-flit filter, FIFO head to arbiter.
// Optional same-cycle bypass on an empty FIFO when ROUTER_INPUT_BYPASS_EN is defined.
module router_input_buffer
  import router_pkg::*;
#(
  parameter int NETWORK_ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int DEPTH                 = 4,
  parameter int LOCAL_X               = 0,
  parameter int LOCAL_Y               = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             inValid,
  output logic                             inReady,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0] destinationAddressIn,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressIn,
  input  logic                             readIn,
  input  logic                             writeIn,
  input  logic [DATA_WIDTH-1:0]            dataIn,
  output logic                             outValid,
  output logic [2:0]                       outDirection,
  output logic [NETWORK_ADDRESS_WIDTH-1:0] destinationAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressOut,
  output logic                             readOut,
  output logic                             writeOut,
  output logic [DATA_WIDTH-1:0]            dataOut,
  input  logic                             outGrant,
  output logic [$clog2(DEPTH):0]           occupancy,
  output logic [7:0]                       malformedCount
);

  localparam int HALF   = NETWORK_ADDRESS_WIDTH / 2;
  localparam int FLIT_W = flit_width(NETWORK_ADDRESS_WIDTH, DATA_WIDTH);

  logic              started;
  logic              well_formed, accept, push, pop, head_valid;
  logic              fifo_full, fifo_empty;
  logic [2:0]        in_dir;
  logic [FLIT_W-1:0] in_flit, fifo_dout, head_flit, out_flit;

  // inReady stays low until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) started <= 1'b0;
    else       started <= 1'b1;
  end

  assign inReady     = started && !fifo_full;
  assign accept      = inValid && inReady;
  assign well_formed = readIn ^ writeIn;
  assign in_dir      = xy_route(COORD_W'(destinationAddressIn[HALF-1:0]),
                                COORD_W'(destinationAddressIn[NETWORK_ADDRESS_WIDTH-1:HALF]),
                                COORD_W'(LOCAL_X), COORD_W'(LOCAL_Y));
  assign in_flit     = {in_dir, destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn};
  assign pop         = outGrant && !fifo_empty;

`ifdef ROUTER_INPUT_BYPASS_EN
  logic bypass;
  assign bypass     = accept && well_formed && fifo_empty;
  assign head_valid = !fifo_empty || bypass;
  assign head_flit  = fifo_empty ? in_flit : fifo_dout;
  // A bypassed flit granted in the same cycle never touches the FIFO.
  assign push       = accept && well_formed && !(bypass && outGrant);
`else
  assign head_valid = !fifo_empty;
  assign head_flit  = fifo_dout;
  assign push       = accept && well_formed;
`endif

  sync_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_flit),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign outValid = head_valid;
  assign out_flit = head_valid ? head_flit : '0;
  assign {outDirection, destinationAddressOut, requesterAddressOut,
          readOut, writeOut, dataOut} = out_flit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                              malformedCount <= '0;
    else if (accept && !well_formed && malformedCount != 8'hFF) malformedCount <= malformedCount + 8'd1;
  end

endmodule

// File: tb/tb_router_input_buffer.sv
// Directed self-checking bench for router_input_buffer (LOCAL_X=1, LOCAL_Y=1, DEPTH=4).
module tb_router_input_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0, inReady;
  logic [3:0]  destinationAddressIn = '0, requesterAddressIn = '0;
  logic        readIn = 1'b0, writeIn = 1'b0;
  logic [31:0] dataIn = '0;
  logic        outValid;
  logic [2:0]  outDirection;
  logic [3:0]  destinationAddressOut, requesterAddressOut;
  logic        readOut, writeOut;
  logic [31:0] dataOut;
  logic        outGrant = 1'b0;
  logic [2:0]  occupancy;
  logic [7:0]  malformedCount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  router_input_buffer #(
    .NETWORK_ADDRESS_WIDTH(4), .DATA_WIDTH(32), .DEPTH(4), .LOCAL_X(1), .LOCAL_Y(1)
  ) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .destinationAddressIn(destinationAddressIn), .requesterAddressIn(requesterAddressIn),
    .readIn(readIn), .writeIn(writeIn), .dataIn(dataIn),
    .outValid(outValid), .outDirection(outDirection),
    .destinationAddressOut(destinationAddressOut), .requesterAddressOut(requesterAddressOut),
    .readOut(readOut), .writeOut(writeOut), .dataOut(dataOut),
    .outGrant(outGrant), .occupancy(occupancy), .malformedCount(malformedCount)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_one(input logic [3:0] d, input logic [3:0] r, input logic rd,
                          input logic wr, input logic [31:0] v);
    inValid = 1'b1; destinationAddressIn = d; requesterAddressIn = r;
    readIn = rd; writeIn = wr; dataIn = v;
    tick();
    inValid = 1'b0;
  endtask

  task automatic grant_one();
    outGrant = 1'b1; tick(); outGrant = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL reset_inReady got=%b exp=0", inReady); end
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (malformedCount !== 8'd0) begin failures++; $display("FAIL reset_malformed got=%0d exp=0", malformedCount); end
    checks++; if ({outDirection, dataOut} !== 35'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {outDirection, dataOut}); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL release_inReady_pre got=%b exp=0", inReady); end
    tick();
    checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL release_inReady_edge got=%b exp=1", inReady); end
  endtask

  task automatic test_route();
    logic [3:0] dl [5] = '{4'b0111, 4'b0101, 4'b0001, 4'b0100, 4'b1001};
    logic [2:0] el [5] = '{3'd3, 3'd0, 3'd1, 3'd4, 3'd2};
    for (int i = 0; i < 5; i++) begin
      push_one(dl[i], 4'h5, 1'b1, 1'b0, 32'hA000 + i);
      checks++; if (outValid !== 1'b1 || outDirection !== el[i])
        begin failures++; $display("FAIL route_%0d got v=%b dir=%0d exp v=1 dir=%0d", i, outValid, outDirection, el[i]); end
      checks++; if (dataOut !== 32'hA000 + i || destinationAddressOut !== dl[i])
        begin failures++; $display("FAIL route_fields_%0d got data=%h dst=%h exp data=%h dst=%h", i, dataOut, destinationAddressOut, 32'hA000 + i, dl[i]); end
      grant_one();
    end
    checks++; if (outValid !== 1'b0 || occupancy !== 3'd0) begin failures++; $display("FAIL route_drain got v=%b occ=%0d exp v=0 occ=0", outValid, occupancy); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_one(4'b0101, 4'h1, 1'b1, 1'b0, 32'd100 + i);
    checks++; if (occupancy !== 3'd4 || inReady !== 1'b0) begin failures++; $display("FAIL full_after4 got occ=%0d rdy=%b exp occ=4 rdy=0", occupancy, inReady); end
    inValid = 1'b1; dataIn = 32'd104;
    tick();
    checks++; if (occupancy !== 3'd4 || dataOut !== 32'd100) begin failures++; $display("FAIL full_held got occ=%0d head=%0d exp occ=4 head=100", occupancy, dataOut); end
    outGrant = 1'b1; tick(); outGrant = 1'b0;
    checks++; if (occupancy !== 3'd3 || inReady !== 1'b1) begin failures++; $display("FAIL full_pop got occ=%0d rdy=%b exp occ=3 rdy=1", occupancy, inReady); end
    tick(); inValid = 1'b0;
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL full_refill got occ=%0d exp=4", occupancy); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (dataOut !== 32'd100 + k) begin failures++; $display("FAIL full_order_%0d got=%0d exp=%0d", k, dataOut, 100 + k); end
      grant_one();
    end
  endtask

  task automatic test_back_to_back();
    push_one(4'b0111, 4'h2, 1'b0, 1'b1, 32'd200);
    push_one(4'b0111, 4'h2, 1'b0, 1'b1, 32'd201);
    for (int i = 0; i < 20; i++) begin
      inValid = 1'b1; dataIn = 32'd202 + i; outGrant = 1'b1;
      #1;
      checks++; if (dataOut !== 32'd200 + i) begin failures++; $display("FAIL b2b_head_%0d got=%0d exp=%0d", i, dataOut, 200 + i); end
      @(posedge clk); #1;
      checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL b2b_occ_%0d got=%0d exp=2", i, occupancy); end
    end
    inValid = 1'b0; outGrant = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (dataOut !== 32'd220 + k) begin failures++; $display("FAIL b2b_tail_%0d got=%0d exp=%0d", k, dataOut, 220 + k); end
      grant_one();
    end
  endtask

  task automatic test_malformed();
    push_one(4'b0101, 4'h3, 1'b1, 1'b1, 32'hBAD);
    checks++; if (malformedCount !== 8'd1 || outValid !== 1'b0) begin failures++; $display("FAIL malformed_first got cnt=%0d v=%b exp cnt=1 v=0", malformedCount, outValid); end
    inValid = 1'b1; readIn = 1'b0; writeIn = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    inValid = 1'b0;
    checks++; if (malformedCount !== 8'd255) begin failures++; $display("FAIL malformed_sat got=%0d exp=255", malformedCount); end
    checks++; if (occupancy !== 3'd0 || outValid !== 1'b0) begin failures++; $display("FAIL malformed_empty got occ=%0d v=%b exp occ=0 v=0", occupancy, outValid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_one(4'b0001, 4'h4, 1'b1, 1'b0, 32'd300 + i);
    #1 reset = 1'b1; #1;
    checks++; if (outValid !== 1'b0 || occupancy !== 3'd0 || inReady !== 1'b0)
      begin failures++; $display("FAIL midreset_ctrl got v=%b occ=%0d rdy=%b exp 0/0/0", outValid, occupancy, inReady); end
    checks++; if ({outDirection, destinationAddressOut, dataOut, malformedCount} !== '0)
      begin failures++; $display("FAIL midreset_fields got dir=%0d data=%h cnt=%0d exp 0", outDirection, dataOut, malformedCount); end
    @(negedge clk); reset = 1'b0;
    tick();
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin failures++; $display("FAIL midreset_release got v=%b rdy=%b exp v=0 rdy=1", outValid, inReady); end
    push_one(4'b0111, 4'h9, 1'b0, 1'b1, 32'hCAFEF00D);
    checks++; if (outValid !== 1'b1 || dataOut !== 32'hCAFEF00D || requesterAddressOut !== 4'h9 ||
                  readOut !== 1'b0 || writeOut !== 1'b1 || outDirection !== 3'd3)
      begin failures++; $display("FAIL midreset_newflit got v=%b data=%h req=%h r=%b w=%b dir=%0d exp 1/cafef00d/9/0/1/3",
                                 outValid, dataOut, requesterAddressOut, readOut, writeOut, outDirection); end
    grant_one();
  endtask

  task automatic test_latency();
    inValid = 1'b1; destinationAddressIn = 4'b0000; readIn = 1'b1; writeIn = 1'b0;
    dataIn = 32'h5A5A; outGrant = 1'b1;
    #1;
`ifdef ROUTER_INPUT_BYPASS_EN
    checks++; if (outValid !== 1'b1 || outDirection !== 3'd4 || dataOut !== 32'h5A5A)
      begin failures++; $display("FAIL bypass_same_cycle got v=%b dir=%0d data=%h exp 1/4/5a5a", outValid, outDirection, dataOut); end
    @(posedge clk); #1; inValid = 1'b0; outGrant = 1'b0;
    checks++; if (occupancy !== 3'd0 || outValid !== 1'b0) begin failures++; $display("FAIL bypass_consumed got occ=%0d v=%b exp occ=0 v=0", occupancy, outValid); end
`else
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL nobypass_same_cycle got v=%b exp 0", outValid); end
    @(posedge clk); #1; inValid = 1'b0;
    checks++; if (outValid !== 1'b1 || occupancy !== 3'd1 || outDirection !== 3'd4)
      begin failures++; $display("FAIL nobypass_next got v=%b occ=%0d dir=%0d exp 1/1/4", outValid, occupancy, outDirection); end
    tick(); outGrant = 1'b0;
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL nobypass_pop got occ=%0d exp 0", occupancy); end
`endif
  endtask

  initial begin
    test_reset();
    test_route();
    test_full();
    test_back_to_back();
    test_malformed();
    test_reset_mid();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_input_buffer.md
# router_input_buffer

Parametrised buffered input port for the mesh cache-bank network router. It accepts request flits from one neighbouring link (or the local cache bank) with a valid/ready handshake and queues them in a DEPTH-entry FIFO. At enqueue it computes the XY dimension-order output direction and presents the head flit plus its direction to the router's output arbiter until granted. Four instances (N/S/E/W) plus one local instance sit inside `router`, replacing the unbuffered port handler.

## Interface
- NETWORK_ADDRESS_WIDTH, 4: node address width, even; upper half = Y, lower half = X
- DATA_WIDTH, 32: payload width
- DEPTH, 4: FIFO entries, power of two, ≥2
- LOCAL_X, 0: this router's X coordinate
- LOCAL_Y, 0: this router's Y coordinate
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- inValid  input  1  upstream flit valid
- inReady  output  1  buffer can accept a flit
- destinationAddressIn  input  NETWORK_ADDRESS_WIDTH  destination node
- requesterAddressIn  input  NETWORK_ADDRESS_WIDTH  originating node
- readIn / writeIn  input  1 each  request type
- dataIn  input  DATA_WIDTH  payload
- outValid  output  1  head flit available
- outDirection  output  3  routed direction of head flit
- destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut  output  as inputs  head flit fields
- outGrant  input  1  arbiter accepts head flit this cycle
- occupancy  output  $clog2(DEPTH)+1  entries held
- malformedCount  output  8  saturating count of dropped malformed flits

## Operation
- Push: inValid && inReady at rising edge. Pop: outValid && outGrant. outGrant with outValid=0 is ignored.
- Malformed flit (readIn == writeIn) is handshaken (consumed) but not stored; malformedCount increments, saturating at 255.
- Routing at enqueue, stored with the flit: destX > LOCAL_X → EAST; destX < LOCAL_X → WEST; else destY > LOCAL_Y → SOUTH; destY < LOCAL_Y → NORTH; else LOCAL. Comparisons are unsigned.
- Direction codes: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4; 5–7 are never driven.
- FIFO: read/write pointers of $clog2(DEPTH) bits wrap naturally. occupancy = DEPTH means full; 0 means empty.
- Simultaneous push and pop while neither full nor empty: occupancy unchanged and both pointers advance.
- Output fields show the head entry when outValid=1 and are driven to 0 when outValid=0.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert is the system's job): FIFO flushed. inReady=0, outValid=0, outDirection=0, all out fields=0, occupancy=0, malformedCount=0. In-flight flits are lost.
- First edge after reset release: inReady=1.
- inReady = (occupancy < DEPTH), registered-state only. There is no combinational path from outGrant to inReady, so when full a same-cycle pop does not allow a push.
- Latency without bypass: a flit pushed at edge N is visible on outValid after edge N.
- outValid holds and the flit is stable until granted. The arbiter may hold outGrant for multiple cycles; each granted cycle pops one flit.

## Configuration
- ROUTER_INPUT_BYPASS_EN defined: when occupancy=0 and a well-formed inValid flit arrives, it appears combinationally on outValid/out fields with its route in the same cycle. If outGrant is also 1, the flit is consumed and not written. Otherwise it is enqueued normally.
- Undefined: minimum latency is one cycle, and no combinational input→output path exists.

## Structure
- router_pkg (shared with router, arbiter, crossbar): direction code constants, flit field layout and width macros, and the XY route function.
- Sub-module: `sync_fifo` (parametrised width/depth, push/pop/full/empty/count). This block wraps it with route computation, malformed filtering, and optional bypass.

## Test plan
- LOCAL_X=1, LOCAL_Y=1, push dest 4'b0111 (Y=1, X=3), readIn=1 → outDirection=3 (EAST). Dest 4'b0101 → 0 (LOCAL). Dest 4'b0001 → 1 (NORTH).
- DEPTH=4, outGrant=0, push 5 flits → inReady=0 after the 4th push, occupancy=4, 5th flit held upstream. Then grant one → inReady=1 the next cycle; FIFO order preserved.
- Continuous push and grant at occupancy=2 for 20 cycles → occupancy stays at 2, pointers wrap, data order intact.
- Push a flit with readIn=1, writeIn=1, then 300 flits with readIn=0, writeIn=0 → nothing enqueued, malformedCount=255 (saturated).
- Fill 3 entries, assert reset mid-cycle → all outputs 0 immediately. After release, outValid=0 and the first new push emerges unaltered.
- With ROUTER_INPUT_BYPASS_EN, empty FIFO, push dest 4'b0000 with outGrant=1 → outValid=1 in the same cycle and occupancy stays 0. Without the macro → outValid rises one cycle later.
